// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU, branch and address generation, plus an
// iterative 32-step multiplier/divider for the M extension.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs_1,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [11:0] i_imm_12,
  input  logic [19:0] i_imm_20,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic [6:0]  i_func_7,
  input  logic        i_flush,
  output logic        stall,
  output logic        o_valid,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic [4:0]  rd_num,
  output logic [6:0]  opcode,
  output logic [2:0]  func_3,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic [2:0]  mf3_q, mf3_d;
  logic [4:0]  mrd_q, mrd_d;

  logic        o_valid_q, o_valid_d;
  logic [31:0] result_q, result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_num_q, rd_num_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  func_3_q, func_3_d;
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;
  logic        illegal_q, illegal_d;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] imm_i, imm_b, imm_j, imm_u, pc_plus4, mem_addr;
  logic [31:0] dec_result, dec_target;
  logic        dec_taken, dec_illegal, dec_store, dec_mop;

  assign imm_i    = {{20{i_imm_12[11]}}, i_imm_12};
  assign imm_b    = {{19{i_imm_12[11]}}, i_imm_12, 1'b0};
  assign imm_j    = {{11{i_imm_20[19]}}, i_imm_20, 1'b0};
  assign imm_u    = {i_imm_20, 12'd0};
  assign pc_plus4 = i_pc + 32'd4;
  assign mem_addr = i_rs_1 + imm_i;

  always_comb begin
    dec_result  = 32'd0;
    dec_target  = 32'd0;
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    dec_store   = 1'b0;
    dec_mop     = 1'b0;
    case (i_opcode)
      OPC_OP_IMM: begin
        // Shift-immediates encode the funct7 in imm[11:5]; only SRLI/SRAI/SLLI forms are legal
        if (i_func_3 == 3'd1)
          dec_illegal = (i_imm_12[11:5] != 7'd0);
        else if (i_func_3 == 3'd5)
          dec_illegal = (i_imm_12[11:5] != 7'd0) && (i_imm_12[11:5] != 7'b0100000);
        dec_result = alu(i_rs_1, imm_i, i_func_3, (i_func_3 == 3'd5) && i_imm_12[10]);
      end
      OPC_OP: begin
        if (i_func_7 == 7'b0000001)
          dec_mop = 1'b1;
        else if (i_func_7 == 7'd0)
          dec_result = alu(i_rs_1, i_rs_2, i_func_3, 1'b0);
        else if (i_func_7 == 7'b0100000 && (i_func_3 == 3'd0 || i_func_3 == 3'd5))
          dec_result = alu(i_rs_1, i_rs_2, i_func_3, 1'b1);
        else
          dec_illegal = 1'b1;
      end
      OPC_LUI:   dec_result = imm_u;
      OPC_AUIPC: dec_result = i_pc + imm_u;
      OPC_JAL: begin
        dec_result = pc_plus4;
        dec_taken  = 1'b1;
        dec_target = i_pc + imm_j;
      end
      OPC_JALR: begin
        dec_illegal = (i_func_3 != 3'd0);
        dec_result  = pc_plus4;
        dec_taken   = 1'b1;
        dec_target  = mem_addr & ~32'd1;
      end
      OPC_BRANCH: begin
        dec_target = i_pc + imm_b;
        case (i_func_3)
          3'd0:    dec_taken = (i_rs_1 == i_rs_2);
          3'd1:    dec_taken = (i_rs_1 != i_rs_2);
          3'd4:    dec_taken = ($signed(i_rs_1) < $signed(i_rs_2));
          3'd5:    dec_taken = ($signed(i_rs_1) >= $signed(i_rs_2));
          3'd6:    dec_taken = (i_rs_1 < i_rs_2);
          3'd7:    dec_taken = (i_rs_1 >= i_rs_2);
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_illegal = (i_func_3 == 3'd3) || (i_func_3 == 3'd6) || (i_func_3 == 3'd7);
        dec_result  = mem_addr;
      end
      OPC_STORE: begin
        dec_illegal = (i_func_3 > 3'd2);
        dec_result  = mem_addr;
        dec_store   = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_result = 32'd0;
      dec_target = 32'd0;
      dec_taken  = 1'b0;
      dec_store  = 1'b0;
    end
  end

  // Operand conditioning: work on magnitudes, remember the sign to apply in DONE
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] div_val, mul_final, div_final;

  always_comb begin
    a_signed  = (i_func_3 == 3'd0) || (i_func_3 == 3'd1) || (i_func_3 == 3'd2) ||
                (i_func_3 == 3'd4) || (i_func_3 == 3'd6);
    b_signed  = (i_func_3 == 3'd0) || (i_func_3 == 3'd1) ||
                (i_func_3 == 3'd4) || (i_func_3 == 3'd6);
    a_neg     = a_signed && i_rs_1[31];
    b_neg     = b_signed && i_rs_2[31];
    a_mag     = a_neg ? -i_rs_1 : i_rs_1;
    b_mag     = b_neg ? -i_rs_2 : i_rs_2;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    mul_final = (mf3_q == 3'd0) ? prod_fix[31:0] : prod_fix[63:32];
    div_val   = mf3_q[1] ? hi_q : lo_q;
    div_final = neg_q ? -div_val : div_val;
  end

  assign stall = rst_n && !i_flush &&
                 ((state_q == IDLE && i_valid && dec_mop) || state_q == CALC);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    opb_d        = opb_q;
    neg_d        = neg_q;
    mf3_d        = mf3_q;
    mrd_d        = mrd_q;
    o_valid_d    = 1'b0;
    br_taken_d   = 1'b0;
    result_d     = result_q;
    store_data_d = store_data_q;
    rd_num_d     = rd_num_q;
    opcode_d     = opcode_q;
    func_3_d     = func_3_q;
    br_target_d  = br_target_q;
    illegal_d    = illegal_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && dec_mop) begin
            state_d = CALC;
            cnt_d   = 5'd0;
            mf3_d   = i_func_3;
            mrd_d   = i_rd_num;
            hi_d    = 32'd0;
            // Multiply: lo holds the multiplier; divide: lo holds the dividend
            lo_d    = i_func_3[2] ? a_mag : b_mag;
            opb_d   = i_func_3[2] ? b_mag : a_mag;
            if (!i_func_3[2])
              neg_d = a_neg ^ b_neg;
            else if (i_func_3[1])
              neg_d = a_neg;
            else
              neg_d = (a_neg ^ b_neg) && (i_rs_2 != 32'd0);
          end else if (i_valid) begin
            o_valid_d   = 1'b1;
            result_d    = dec_result;
            br_taken_d  = dec_taken;
            br_target_d = dec_target;
            illegal_d   = dec_illegal;
            rd_num_d    = i_rd_num;
            opcode_d    = i_opcode;
            func_3_d    = i_func_3;
            if (dec_store)
              store_data_d = i_rs_2;
          end
        end
        CALC: begin
          if (mf3_q[2]) begin
            if (!div_diff[32]) begin
              hi_d = div_diff[31:0];
              lo_d = {lo_q[30:0], 1'b1};
            end else begin
              hi_d = div_shift[31:0];
              lo_d = {lo_q[30:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[32:1];
            lo_d = {mul_sum[0], lo_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31)
            state_d = DONE;
        end
        DONE: begin
          o_valid_d   = 1'b1;
          result_d    = mf3_q[2] ? div_final : mul_final;
          br_target_d = 32'd0;
          illegal_d   = 1'b0;
          rd_num_d    = mrd_q;
          opcode_d    = OPC_OP;
          func_3_d    = mf3_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      opb_q        <= 32'd0;
      neg_q        <= 1'b0;
      mf3_q        <= 3'd0;
      mrd_q        <= 5'd0;
      o_valid_q    <= 1'b0;
      result_q     <= 32'd0;
      store_data_q <= 32'd0;
      rd_num_q     <= 5'd0;
      opcode_q     <= 7'd0;
      func_3_q     <= 3'd0;
      br_taken_q   <= 1'b0;
      br_target_q  <= 32'd0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      opb_q        <= opb_d;
      neg_q        <= neg_d;
      mf3_q        <= mf3_d;
      mrd_q        <= mrd_d;
      o_valid_q    <= o_valid_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      rd_num_q     <= rd_num_d;
      opcode_q     <= opcode_d;
      func_3_q     <= func_3_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
      illegal_q    <= illegal_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign result     = result_q;
  assign store_data = store_data_q;
  assign rd_num     = rd_num_q;
  assign opcode     = opcode_q;
  assign func_3     = func_3_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, randomized single-cycle ops
// against an ISA-level model, and hand-written multi-cycle M-op / flush / reset sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_flush = 1'b0;
  logic [31:0] i_pc = '0, i_rs_1 = '0, i_rs_2 = '0;
  logic [4:0]  i_rd_num = '0;
  logic [11:0] i_imm_12 = '0;
  logic [19:0] i_imm_20 = '0;
  logic [6:0]  i_opcode = '0, i_func_7 = '0;
  logic [2:0]  i_func_3 = '0;
  logic        stall, o_valid, br_taken, illegal;
  logic [31:0] result, store_data, br_target;
  logic [4:0]  rd_num;
  logic [6:0]  opcode;
  logic [2:0]  func_3;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_pc(i_pc), .i_rs_1(i_rs_1),
    .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .i_imm_12(i_imm_12), .i_imm_20(i_imm_20),
    .i_opcode(i_opcode), .i_func_3(i_func_3), .i_func_7(i_func_7), .i_flush(i_flush),
    .stall(stall), .o_valid(o_valid), .result(result), .store_data(store_data),
    .rd_num(rd_num), .opcode(opcode), .func_3(func_3), .br_taken(br_taken),
    .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural state of the output registers
  logic [31:0] e_res = '0, e_sd = '0, e_tgt = '0;
  logic [4:0]  e_rd = '0;
  logic [6:0]  e_op = '0;
  logic [2:0]  e_f3 = '0;
  logic        e_ov = 1'b0, e_tk = 1'b0, e_ill = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".o_valid"},    32'(o_valid),    32'(e_ov));
    chk({tag, ".result"},     result,          e_res);
    chk({tag, ".store_data"}, store_data,      e_sd);
    chk({tag, ".rd_num"},     32'(rd_num),     32'(e_rd));
    chk({tag, ".opcode"},     32'(opcode),     32'(e_op));
    chk({tag, ".func_3"},     32'(func_3),     32'(e_f3));
    chk({tag, ".br_taken"},   32'(br_taken),   32'(e_tk));
    chk({tag, ".br_target"},  br_target,       e_tgt);
    chk({tag, ".illegal"},    32'(illegal),    32'(e_ill));
  endtask

  task automatic set_in(input logic v, input logic fl, input logic [6:0] op,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [11:0] i12, input logic [19:0] i20, input logic [4:0] rd);
    i_valid = v;   i_flush = fl;  i_opcode = op;  i_func_3 = f3;  i_func_7 = f7;
    i_pc = pc;     i_rs_1 = rs1;  i_rs_2 = rs2;   i_imm_12 = i12; i_imm_20 = i20;
    i_rd_num = rd;
  endtask

  // ISA-level reference for the single-cycle instruction classes
  function automatic void ref_single(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] pc, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [11:0] i12, input logic [19:0] i20,
      output logic [31:0] res, output logic tk, output logic [31:0] tgt, output logic ill);
    int s1, s2, si;
    logic [31:0] ui;
    s1 = rs1; s2 = rs2; si = {{20{i12[11]}}, i12}; ui = si;
    res = '0; tk = 1'b0; tgt = '0; ill = 1'b0;
    case (op)
      7'h13: case (f3)
        3'd0: res = rs1 + ui;
        3'd1: begin ill = (i12[11:5] != 7'h00); res = rs1 << i12[4:0]; end
        3'd2: res = (s1 < si) ? 32'd1 : 32'd0;
        3'd3: res = (rs1 < ui) ? 32'd1 : 32'd0;
        3'd4: res = rs1 ^ ui;
        3'd5: if (i12[11:5] == 7'h00) res = rs1 >> i12[4:0];
              else if (i12[11:5] == 7'h20) res = s1 >>> i12[4:0];
              else ill = 1'b1;
        3'd6: res = rs1 | ui;
        default: res = rs1 & ui;
      endcase
      7'h33: if (f7 == 7'h00) begin
        case (f3)
          3'd0: res = rs1 + rs2;
          3'd1: res = rs1 << rs2[4:0];
          3'd2: res = (s1 < s2) ? 32'd1 : 32'd0;
          3'd3: res = (rs1 < rs2) ? 32'd1 : 32'd0;
          3'd4: res = rs1 ^ rs2;
          3'd5: res = rs1 >> rs2[4:0];
          3'd6: res = rs1 | rs2;
          default: res = rs1 & rs2;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) res = rs1 - rs2;
      else if (f7 == 7'h20 && f3 == 3'd5) res = s1 >>> rs2[4:0];
      else ill = 1'b1;
      7'h37: res = {i20, 12'h000};
      7'h17: res = pc + {i20, 12'h000};
      7'h6F: begin res = pc + 4; tk = 1'b1; tgt = pc + {{11{i20[19]}}, i20, 1'b0}; end
      7'h67: if (f3 != 3'd0) ill = 1'b1;
             else begin res = pc + 4; tk = 1'b1; tgt = (rs1 + ui) & 32'hFFFF_FFFE; end
      7'h63: begin
        tgt = pc + (ui << 1);
        case (f3)
          3'd0: tk = (rs1 == rs2);
          3'd1: tk = (rs1 != rs2);
          3'd4: tk = (s1 < s2);
          3'd5: tk = (s1 >= s2);
          3'd6: tk = (rs1 < rs2);
          3'd7: tk = (rs1 >= rs2);
          default: ill = 1'b1;
        endcase
      end
      7'h03: if (f3 == 3'd3 || f3 > 3'd5) ill = 1'b1; else res = rs1 + ui;
      7'h23: if (f3 > 3'd2) ill = 1'b1; else res = rs1 + ui;
      default: ill = 1'b1;
    endcase
    if (ill) begin res = '0; tk = 1'b0; tgt = '0; end
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    ia = a; ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return ia / ib;
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return ia % ib;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    int stall_cyc, edges, early_ov;
    logic [31:0] exp_r;
    exp_r = ref_m(f3, a, b);
    set_in(1'b1, 1'b0, 7'h33, f3, 7'h01, $urandom, a, b, 12'h0, 20'h0, rd);
    #1;
    chk({name, ".stall_on_accept"}, 32'(stall), 32'd1);
    stall_cyc = 1; edges = 0; early_ov = 0;
    while (edges < 40) begin
      @(posedge clk); #1; edges++;
      if (o_valid) early_ov++;
      if (stall) stall_cyc++; else break;
    end
    i_valid = 1'b0;
    chk({name, ".stall_cycles"}, stall_cyc, 33);
    chk({name, ".no_early_valid"}, early_ov, 0);
    while (!o_valid && edges < 60) begin
      @(posedge clk); #1; edges++;
    end
    chk({name, ".latency"}, edges, 34);
    e_ov = 1'b1; e_res = exp_r; e_rd = rd; e_op = 7'h33; e_f3 = f3;
    e_tk = 1'b0; e_tgt = '0; e_ill = 1'b0;
    check_all(name);
    $display("mop %s f3=%0d a=%h b=%h -> %h (expect %h) in %0d cycles",
             name, f3, a, b, result, exp_r, edges);
    @(posedge clk); #1;
    e_ov = 1'b0;
    chk({name, ".pulse_one_cycle"}, 32'(o_valid), 32'd0);
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] pc, rs1, rs2; logic [11:0] i12; logic [19:0] i20; logic [4:0] rd;
    logic [31:0] x_res; logic x_tk; logic [31:0] x_tgt; logic x_ill;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] illegal_ops[4];
    tbl[0]  = '{7'h13, 3'd0, 7'h00, 32'h0, 32'd5, 32'd0, 12'hFFF, 20'h0, 5'd7,
                32'd4, 1'b0, 32'h0, 1'b0};                       // ADDI 5 + -1
    tbl[1]  = '{7'h63, 3'd4, 7'h00, 32'h100, 32'hFFFF_FFFF, 32'd1, 12'h008, 20'h0, 5'd0,
                32'd0, 1'b1, 32'h110, 1'b0};                     // BLT taken
    tbl[2]  = '{7'h37, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 12'h0, 20'h12345, 5'd3,
                32'h1234_5000, 1'b0, 32'h0, 1'b0};               // LUI
    tbl[3]  = '{7'h17, 3'd0, 7'h00, 32'h1000, 32'h0, 32'h0, 12'h0, 20'hFFFFF, 5'd4,
                32'h0, 1'b0, 32'h0, 1'b0};                       // AUIPC wraps
    tbl[4]  = '{7'h6F, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'h0, 32'h0, 12'h0, 20'h00004, 5'd1,
                32'h0, 1'b1, 32'h4, 1'b0};                       // JAL, PC wrap
    tbl[5]  = '{7'h67, 3'd0, 7'h00, 32'h200, 32'h1001, 32'h0, 12'h004, 20'h0, 5'd1,
                32'h204, 1'b1, 32'h1004, 1'b0};                  // JALR clears bit 0
    tbl[6]  = '{7'h13, 3'd5, 7'h00, 32'h0, 32'h8000_0000, 32'h0, 12'h404, 20'h0, 5'd5,
                32'hF800_0000, 1'b0, 32'h0, 1'b0};               // SRAI 4
    tbl[7]  = '{7'h33, 3'd0, 7'h20, 32'h0, 32'd3, 32'd5, 12'h0, 20'h0, 5'd6,
                32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0};               // SUB
    tbl[8]  = '{7'h33, 3'd3, 7'h00, 32'h0, 32'd1, 32'hFFFF_FFFF, 12'h0, 20'h0, 5'd8,
                32'd1, 1'b0, 32'h0, 1'b0};                       // SLTU
    tbl[9]  = '{7'h03, 3'd2, 7'h00, 32'h0, 32'h1000, 32'h0, 12'hFFC, 20'h0, 5'd9,
                32'hFFC, 1'b0, 32'h0, 1'b0};                     // LW address
    tbl[10] = '{7'h23, 3'd2, 7'h00, 32'h0, 32'h2000, 32'hDEAD_BEEF, 12'h010, 20'h0, 5'd0,
                32'h2010, 1'b0, 32'h0, 1'b0};                    // SW
    tbl[11] = '{7'h63, 3'd0, 7'h00, 32'h40, 32'd1, 32'd2, 12'hFFE, 20'h0, 5'd0,
                32'h0, 1'b0, 32'h3C, 1'b0};                      // BEQ not taken
    tbl[12] = '{7'h7F, 3'd0, 7'h00, 32'h0, 32'd1, 32'd2, 12'h0, 20'h0, 5'd10,
                32'h0, 1'b0, 32'h0, 1'b1};                       // unknown opcode
    tbl[13] = '{7'h33, 3'd5, 7'h20, 32'h0, 32'h8000_0010, 32'h24, 12'h0, 20'h0, 5'd11,
                32'hF800_0001, 1'b0, 32'h0, 1'b0};               // SRA uses rs2[4:0]
    tbl[14] = '{7'h13, 3'd1, 7'h00, 32'h0, 32'd1, 32'h0, 12'h420, 20'h0, 5'd12,
                32'h0, 1'b0, 32'h0, 1'b1};                       // bad SLLI funct7
    tbl[15] = '{7'h13, 3'd1, 7'h00, 32'h0, 32'd1, 32'h0, 12'h003, 20'h0, 5'd13,
                32'd8, 1'b0, 32'h0, 1'b0};                       // SLLI 3
    illegal_ops = '{7'h7F, 7'h0B, 7'h2F, 7'h00};

    // Reset state
    #1;
    check_all("reset");
    chk("reset.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b0, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].pc, tbl[i].rs1,
             tbl[i].rs2, tbl[i].i12, tbl[i].i20, tbl[i].rd);
      @(posedge clk); #1;
      e_ov = 1'b1; e_res = tbl[i].x_res; e_tk = tbl[i].x_tk; e_tgt = tbl[i].x_tgt;
      e_ill = tbl[i].x_ill; e_rd = tbl[i].rd; e_op = tbl[i].op; e_f3 = tbl[i].f3;
      if (tbl[i].op == 7'h23) e_sd = tbl[i].rs2;
      check_all($sformatf("vec%0d", i));
      $display("vec %0d op=%h f3=%0d -> result=%h br=%0d tgt=%h ill=%0d",
               i, tbl[i].op, tbl[i].f3, result, br_taken, br_target, illegal);
    end

    // Idle cycle: valid/taken drop, everything else holds
    i_valid = 1'b0;
    @(posedge clk); #1;
    e_ov = 1'b0; e_tk = 1'b0;
    check_all("idle_hold");

    // Randomized single-cycle traffic with idles and flushes
    for (int n = 0; n < 300; n++) begin
      logic [6:0] op, f7; logic [2:0] f3; logic [31:0] pc, rs1, rs2;
      logic [11:0] i12; logic [19:0] i20; logic [4:0] rd; logic v, fl;
      logic [31:0] r_res, r_tgt; logic r_tk, r_ill;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 7'h13; 1: op = 7'h33; 2: op = 7'h37; 3: op = 7'h17; 4: op = 7'h6F;
        5: op = 7'h67; 6: op = 7'h63; 7: op = 7'h03; 8: op = 7'h23;
        default: op = illegal_ops[$urandom_range(0, 3)];
      endcase
      f3 = 3'($urandom); i12 = 12'($urandom); i20 = 20'($urandom); rd = 5'($urandom);
      pc = $urandom; rs1 = $urandom; rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      if (f7 == 7'h01) f7 = 7'h02;
      if (op == 7'h13 && $urandom_range(0, 2) != 0)
        i12[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (op == 7'h67 && $urandom_range(0, 2) != 0) f3 = 3'd0;
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 19) == 0);
      set_in(v, fl, op, f3, f7, pc, rs1, rs2, i12, i20, rd);
      @(posedge clk); #1;
      ref_single(op, f3, f7, pc, rs1, rs2, i12, i20, r_res, r_tk, r_tgt, r_ill);
      if (v && !fl) begin
        e_ov = 1'b1; e_res = r_res; e_tk = r_tk; e_tgt = r_tgt; e_ill = r_ill;
        e_rd = rd; e_op = op; e_f3 = f3;
        if (op == 7'h23 && !r_ill) e_sd = rs2;
      end else begin
        e_ov = 1'b0; e_tk = 1'b0;
      end
      check_all($sformatf("rand%0d", n));
      $display("rand %0d v=%0d fl=%0d op=%h f3=%0d -> ov=%0d result=%h br=%0d ill=%0d",
               n, v, fl, op, f3, o_valid, result, br_taken, illegal);
    end
    i_flush = 1'b0;

    // Multi-cycle M operations: directed corner cases then random operands
    run_mop("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd14);
    run_mop("div_by0",  3'd4, 32'd7, 32'd0, 5'd15);
    run_mop("rem_by0",  3'd6, 32'd7, 32'd0, 5'd16);
    run_mop("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    run_mop("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18);
    run_mop("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 5'd19);
    run_mop("mul_neg",  3'd0, 32'hFFFF_FFFD, 32'd7, 5'd20);
    for (int n = 0; n < 14; n++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (n % 4 == 1) b = b >> $urandom_range(0, 31);
      if (n % 4 == 2) a = -a;
      run_mop($sformatf("mrand%0d", n), 3'($urandom), a, b, 5'($urandom));
    end

    // Flush ten cycles into a DIVU
    set_in(1'b1, 1'b0, 7'h33, 3'd5, 7'h01, 32'h0, 32'd100, 32'd7, 12'h0, 20'h0, 5'd21);
    #1;
    chk("flush.stall_on_accept", 32'(stall), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    i_flush = 1'b1; i_valid = 1'b0;
    #1;
    chk("flush.stall_during_flush", 32'(stall), 32'd0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush.stall_after", 32'(stall), 32'd0);
    e_ov = 1'b0; e_tk = 1'b0;
    check_all("flush.after");
    begin
      int ov_cnt;
      ov_cnt = 0;
      repeat (40) begin @(posedge clk); #1; if (o_valid) ov_cnt++; end
      chk("flush.no_valid", ov_cnt, 0);
    end
    set_in(1'b1, 1'b0, 7'h33, 3'd0, 7'h00, 32'h0, 32'd3, 32'd4, 12'h0, 20'h0, 5'd22);
    @(posedge clk); #1;
    i_valid = 1'b0;
    e_ov = 1'b1; e_res = 32'd7; e_rd = 5'd22; e_op = 7'h33; e_f3 = 3'd0;
    e_tk = 1'b0; e_tgt = '0; e_ill = 1'b0;
    check_all("flush.add_next");
    $display("flush test: ADD after flush -> ov=%0d result=%h", o_valid, result);

    // Reset asserted mid-CALC
    set_in(1'b1, 1'b0, 7'h33, 3'd3, 7'h01, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           12'h0, 20'h0, 5'd23);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    e_ov = 1'b0; e_res = '0; e_sd = '0; e_tgt = '0; e_rd = '0; e_op = '0; e_f3 = '0;
    e_tk = 1'b0; e_ill = 1'b0;
    check_all("rst_mid.immediate");
    chk("rst_mid.stall", 32'(stall), 32'd0);
    i_valid = 1'b0;
    @(posedge clk); #1;
    check_all("rst_mid.held");
    #2;
    rst_n = 1'b1;
    set_in(1'b1, 1'b0, 7'h6F, 3'd0, 7'h00, 32'h3000, 32'h0, 32'h0, 12'h0, 20'h00010, 5'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    e_ov = 1'b1; e_res = 32'h3004; e_tk = 1'b1; e_tgt = 32'h3020; e_rd = 5'd1;
    e_op = 7'h6F; e_f3 = 3'd0; e_ill = 1'b0;
    check_all("rst_mid.jal");
    $display("reset test: JAL after release -> result=%h tgt=%h", result, br_target);
    begin
      int ov_cnt;
      ov_cnt = 0;
      @(posedge clk); #1;
      repeat (40) begin @(posedge clk); #1; if (o_valid) ov_cnt++; end
      chk("rst_mid.no_stale_valid", ov_cnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
